cmd_screen_fifo: RTL and testbench
==================================

Name: cmd_screen_fifo

Overview:
Sits between UART_wrapper and cmd_proc. It screens each incoming 16-bit command against a parametrised set of legal opcodes. Legal commands are buffered in a DEPTH-entry FIFO for cmd_proc. Illegal commands, and commands arriving while the FIFO is full, are dropped, counted, and answered with a reject byte on the response path. This generalises cmd_proc's "stay in IDLE on bad opcode" rule into configurable, observable filtering with queuing.

Parameters:
CMD_W, 16, command width.
OP_W, 4, opcode width; opcode = cmd[CMD_W-1 -: OP_W].
DEPTH, 4, FIFO entries; any integer >= 2, need not be a power of 2.
VALID_MASK, 16'h001C, bit i set means opcode i is legal (default: opcodes 2, 3, 4); width 2**OP_W.
NACK_BYTE, 8'hEE, response for an illegal opcode.
FULL_BYTE, 8'hEF, response for a legal command dropped because the FIFO is full.
ERR_W, 8, width of the reject counter.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_in  in  CMD_W  command from UART_wrapper
cmd_in_rdy  in  1  level, high while cmd_in is valid
clr_cmd_in_rdy  out  1  one-cycle pulse acknowledging capture of cmd_in
cmd_out  out  CMD_W  FIFO head
cmd_out_rdy  out  1  FIFO not empty
clr_cmd_out_rdy  in  1  pop strobe from cmd_proc
resp_out  out  8  reject byte
send_resp  out  1  one-cycle pulse; resp_out valid in the same cycle
resp_busy  in  1  response transmitter busy
fifo_cnt  out  $clog2(DEPTH+1)  current occupancy
err_cnt  out  ERR_W  saturating count of rejected commands
overflow  out  1  sticky; set when a legal command is dropped because the FIFO is full
clr_err  in  1  clears err_cnt and overflow

Behaviour:
- Reset (sync, rst high at posedge): state=IDLE, FIFO empty, cmd_out_rdy=0, fifo_cnt=0, err_cnt=0, overflow=0, clr_cmd_in_rdy=0, send_resp=0, resp_out=8'h00. cmd_out is don't-care while empty. Reset mid-operation aborts any pending response and discards FIFO contents.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - if cmd_in_rdy is high at edge k: latch cmd_in into cmd_q, pulse clr_cmd_in_rdy during cycle k+1, go to CHECK.
- CHECK (one cycle), op = cmd_q opcode field:
  - VALID_MASK[op]=1 and not full: push at edge k+1; cmd_out_rdy visible at k+2 if FIFO was empty; go to IDLE.
  - VALID_MASK[op]=1 and full: drop, set overflow, err_cnt+1, resp_q=FULL_BYTE, go to RESP.
  - VALID_MASK[op]=0: drop, err_cnt+1, resp_q=NACK_BYTE, go to RESP.
- RESP:
  - wait while resp_busy=1.
  - first cycle with resp_busy=0: send_resp=1 for exactly one cycle with resp_out=resp_q, then go to IDLE.
- cmd_in_rdy is ignored outside IDLE. The command stays pending upstream and is taken on return to IDLE.
- Full/pop interaction:
  - "full" means fifo_cnt==DEPTH, sampled at the start of the cycle.
  - A push and a pop in the same cycle while full are both accepted; count is unchanged and no overflow.
  - A push and a pop in the same cycle while empty: push proceeds, pop is ignored (pop on empty is always ignored).
- Pointers: write and read pointers wrap from DEPTH-1 to 0. fifo_cnt = pushes minus pops, range 0..DEPTH.
- cmd_out always shows mem[rd_ptr]. The new head appears the cycle after a pop.
- err_cnt saturates at 2**ERR_W-1.
- clr_err priority:
  - clr_err and an increment in the same cycle: result is 1.
  - clr_err and an overflow set in the same cycle: overflow ends at 1.
- Legal commands produce no response from this block; cmd_proc owns the positive ack.

Test Plan:
1. Reset; send 16'h2FFF (op 2) -> clr_cmd_in_rdy pulse 1 cycle after capture, cmd_out_rdy=1 and cmd_out=16'h2FFF 2 cycles after capture, fifo_cnt=1, no send_resp.
2. Loop all 16 opcodes with data 12'hFFF: ops 2, 3, 4 enqueue (pop between); the other 13 each give send_resp with resp_out=8'hEE -> err_cnt=13, overflow=0.
3. Send 5 legal commands with no pops, DEPTH=4 -> fifo_cnt=4, 5th answered 8'hEF, overflow=1, err_cnt=1. Pops return commands 1-4 in order, then cmd_out_rdy=0.
4. Full FIFO; push a legal command while clr_cmd_out_rdy=1 in the CHECK cycle -> fifo_cnt stays 4, no overflow. Drain shows wrap-around ordering is correct.
5. Illegal opcode with resp_busy held high 20 cycles -> send_resp fires exactly on the first cycle resp_busy=0. A second cmd_in_rdy during the wait is captured only after RESP exits.
6. Assert rst during RESP with 3 entries queued -> next cycle fifo_cnt=0, cmd_out_rdy=0, send_resp never fires. Separately, clr_err coincident with a reject -> err_cnt=1.

Source files
------------

// File: rtl/cmd_screen_fifo_if.sv
// cmd_screen_fifo_if: command-in, command-out and response handshake bundle
interface cmd_screen_fifo_if #(
  parameter int CMD_W = 16
);
  logic [CMD_W-1:0] cmd_in;
  logic             cmd_in_rdy;
  logic             clr_cmd_in_rdy;
  logic [CMD_W-1:0] cmd_out;
  logic             cmd_out_rdy;
  logic             clr_cmd_out_rdy;
  logic [7:0]       resp_out;
  logic             send_resp;
  logic             resp_busy;
  modport master (
    output cmd_in, cmd_in_rdy, clr_cmd_out_rdy, resp_busy,
    input  clr_cmd_in_rdy, cmd_out, cmd_out_rdy, resp_out, send_resp
  );
  modport slave (
    input  cmd_in, cmd_in_rdy, clr_cmd_out_rdy, resp_busy,
    output clr_cmd_in_rdy, cmd_out, cmd_out_rdy, resp_out, send_resp
  );
endinterface

// File: rtl/cmd_screen_fifo.sv
// cmd_screen_fifo: screens commands by opcode, queues legal ones, rejects the rest
module cmd_screen_fifo #(
  parameter int                    CMD_W      = 16,
  parameter int                    OP_W       = 4,
  parameter int                    DEPTH      = 4,
  parameter logic [2**OP_W-1:0]    VALID_MASK = 16'h001C,
  parameter logic [7:0]            NACK_BYTE  = 8'hEE,
  parameter logic [7:0]            FULL_BYTE  = 8'hEF,
  parameter int                    ERR_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  cmd_screen_fifo_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
  output logic [ERR_W-1:0]             err_cnt,
  output logic                         overflow,
  input  logic                         clr_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  state_t           state, state_n;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CMD_W-1:0] cmd_q;
  logic [7:0]       resp_q;
  logic             clr_q;
  logic [OP_W-1:0]  op;
  logic             legal, full, pop, push, reject, ovf_set;
  assign bus.clr_cmd_in_rdy = clr_q;
  assign bus.cmd_out        = mem[rd_ptr];
  assign bus.cmd_out_rdy    = fifo_cnt != '0;
  assign bus.resp_out       = resp_q;
  // screening decision, FIFO strobes, next state and response strobe
  always_comb begin
    op        = cmd_q[CMD_W-1 -: OP_W];
    legal     = VALID_MASK[op];
    full      = fifo_cnt == CW'(DEPTH);
    pop       = bus.clr_cmd_out_rdy && fifo_cnt != '0;
    push      = state == CHECK && legal && (!full || pop);
    reject    = state == CHECK && !push;
    ovf_set   = reject && legal;
    state_n   = state == IDLE  ? (bus.cmd_in_rdy ? CHECK : IDLE) :
                state == CHECK ? (push ? IDLE : RESP) :
                                 (bus.resp_busy ? RESP : IDLE);
    bus.send_resp = state == RESP && !bus.resp_busy;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // command capture, acknowledge pulse and reject byte selection
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      clr_q  <= 1'b0;
      resp_q <= 8'h00;
    end else begin
      clr_q <= state == IDLE && bus.cmd_in_rdy;
      if (state == IDLE && bus.cmd_in_rdy) cmd_q <= bus.cmd_in;
      if (reject) resp_q <= legal ? FULL_BYTE : NACK_BYTE;
    end
  end
  // FIFO storage, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= cmd_q;
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end
  // reject statistics; a clear coinciding with an event keeps that event
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (clr_err) err_cnt <= reject ? ERR_W'(1) : '0;
      else if (reject && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      overflow <= clr_err ? ovf_set : overflow | ovf_set;
    end
  end
endmodule

// File: tb/tb_cmd_screen_fifo.sv
// tb_cmd_screen_fifo: directed self-checking bench for cmd_screen_fifo
module tb_cmd_screen_fifo;
  logic       clk = 0;
  logic       rst = 1;
  logic       clr_err = 0;
  logic [2:0] fifo_cnt;
  logic [7:0] err_cnt;
  logic       overflow;
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         lat, fires, seen;
  logic [15:0] mask = 16'h001C;
  logic [15:0] c;
  cmd_screen_fifo_if #(.CMD_W(16)) bus ();
  cmd_screen_fifo dut (
    .clk(clk), .rst(rst), .bus(bus),
    .fifo_cnt(fifo_cnt), .err_cnt(err_cnt), .overflow(overflow), .clr_err(clr_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  // raise cmd_in_rdy until the acknowledge pulse is seen; returns in the CHECK cycle
  task automatic send(input logic [15:0] cmd, output int n);
    bus.cmd_in = cmd;
    bus.cmd_in_rdy = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.clr_cmd_in_rdy && n < 50);
    check("clr_cmd_in_rdy", bus.clr_cmd_in_rdy, 1);
    bus.cmd_in_rdy = 0;
  endtask
  task automatic pop();
    bus.clr_cmd_out_rdy = 1;
    @(negedge clk);
    bus.clr_cmd_out_rdy = 0;
  endtask
  initial begin
    bus.cmd_in = '0;
    bus.cmd_in_rdy = 0;
    bus.clr_cmd_out_rdy = 0;
    bus.resp_busy = 0;
    // 1: reset state and a single legal command
    do_reset();
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_cmd_out_rdy", bus.cmd_out_rdy, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_clr", bus.clr_cmd_in_rdy, 0);
    check("rst_send_resp", bus.send_resp, 0);
    check("rst_resp_out", bus.resp_out, 8'h00);
    send(16'h2FFF, lat);
    check("t1_ack_latency", lat, 1);
    check("t1_no_resp_check", bus.send_resp, 0);
    @(negedge clk);
    check("t1_cmd_out_rdy", bus.cmd_out_rdy, 1);
    check("t1_cmd_out", bus.cmd_out, 16'h2FFF);
    check("t1_fifo_cnt", fifo_cnt, 1);
    check("t1_clr_one_cycle", bus.clr_cmd_in_rdy, 0);
    check("t1_no_resp", bus.send_resp, 0);
    // 2: every opcode
    do_reset();
    for (int op = 0; op < 16; op++) begin
      c = {op[3:0], 12'hFFF};
      send(c, lat);
      @(negedge clk);
      if (mask[op]) begin
        check("t2_legal_rdy", bus.cmd_out_rdy, 1);
        check("t2_legal_data", bus.cmd_out, c);
        check("t2_legal_no_resp", bus.send_resp, 0);
        pop();
      end else begin
        check("t2_nack_send", bus.send_resp, 1);
        check("t2_nack_byte", bus.resp_out, 8'hEE);
        @(negedge clk);
        check("t2_send_one_cycle", bus.send_resp, 0);
      end
    end
    check("t2_err_cnt", err_cnt, 13);
    check("t2_overflow", overflow, 0);
    check("t2_fifo_cnt", fifo_cnt, 0);
    // 3: overflow on the fifth legal command
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(16'h3000 + 16'(i), lat);
      @(negedge clk);
    end
    check("t3_full_cnt", fifo_cnt, 4);
    send(16'h3005, lat);
    @(negedge clk);
    check("t3_full_send", bus.send_resp, 1);
    check("t3_full_byte", bus.resp_out, 8'hEF);
    check("t3_overflow", overflow, 1);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_cnt_kept", fifo_cnt, 4);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain", bus.cmd_out, 16'h3000 + 16'(i));
      pop();
    end
    check("t3_empty_rdy", bus.cmd_out_rdy, 0);
    check("t3_empty_cnt", fifo_cnt, 0);
    // 4: push and pop together while full, then wrapped drain
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    check("t4_clr_err", err_cnt, 0);
    check("t4_clr_ovf", overflow, 0);
    for (int i = 1; i <= 4; i++) begin
      send(16'h4010 + 16'(i), lat);
      @(negedge clk);
    end
    send(16'h2015, lat);
    pop();
    check("t4_cnt_same", fifo_cnt, 4);
    check("t4_no_ovf", overflow, 0);
    check("t4_no_err", err_cnt, 0);
    check("t4_no_resp", bus.send_resp, 0);
    check("t4_drain0", bus.cmd_out, 16'h4012);
    pop();
    check("t4_drain1", bus.cmd_out, 16'h4013);
    pop();
    check("t4_drain2", bus.cmd_out, 16'h4014);
    pop();
    check("t4_drain3", bus.cmd_out, 16'h2015);
    pop();
    check("t4_empty", bus.cmd_out_rdy, 0);
    // 5: response held off by resp_busy, second command waits
    bus.resp_busy = 1;
    send(16'h9ABC, lat);
    bus.cmd_in = 16'h2123;
    bus.cmd_in_rdy = 1;
    fires = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      fires += int'(bus.send_resp);
      seen += int'(bus.clr_cmd_in_rdy);
    end
    check("t5_no_send_busy", fires, 0);
    check("t5_no_capture_busy", seen, 0);
    bus.resp_busy = 0;
    #1;
    check("t5_send", bus.send_resp, 1);
    check("t5_byte", bus.resp_out, 8'hEE);
    lat = 0;
    while (!bus.clr_cmd_in_rdy && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("t5_second_ack", bus.clr_cmd_in_rdy, 1);
    check("t5_second_latency", lat, 2);
    bus.cmd_in_rdy = 0;
    @(negedge clk);
    check("t5_second_data", bus.cmd_out, 16'h2123);
    check("t5_cnt", fifo_cnt, 1);
    check("t5_err", err_cnt, 1);
    // 6: reset during a pending response
    send(16'h3A01, lat);
    @(negedge clk);
    send(16'h3A02, lat);
    @(negedge clk);
    check("t6_cnt3", fifo_cnt, 3);
    bus.resp_busy = 1;
    send(16'h0000, lat);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t6_rst_cnt", fifo_cnt, 0);
    check("t6_rst_rdy", bus.cmd_out_rdy, 0);
    check("t6_rst_send", bus.send_resp, 0);
    check("t6_rst_err", err_cnt, 0);
    rst = 0;
    bus.resp_busy = 0;
    fires = 0;
    repeat (5) begin
      @(negedge clk);
      fires += int'(bus.send_resp);
    end
    check("t6_no_send_after_rst", fires, 0);
    send(16'hF000, lat);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    check("t6_clr_inc_err", err_cnt, 1);
    check("t6_clr_inc_send", bus.send_resp, 1);
    check("t6_clr_inc_byte", bus.resp_out, 8'hEE);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      send(16'h3B00 + 16'(i), lat);
      @(negedge clk);
    end
    send(16'h3B05, lat);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    check("t6_clr_ovf", overflow, 1);
    check("t6_clr_ovf_err", err_cnt, 1);
    check("t6_clr_ovf_byte", bus.resp_out, 8'hEF);
    check("t6_clr_ovf_cnt", fifo_cnt, 4);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
